// File: rtl/data_memory_pipe.sv
// Byte-addressed data RAM with a request/response handshake and a fixed-latency,
// stall-able response pipeline. Loads and stores of 1, 2 or 4 bytes; misaligned or malformed requests fault.
module data_memory_pipe #(
  parameter int WIDTH        = 32,
  parameter int RAM_SIZE     = 4096,
  parameter int READ_LATENCY = 1,
  parameter bit BIG_ENDIAN   = 1'b1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic             req_store,
  input  logic [1:0]       req_size,
  input  logic             req_sign_extend,
  input  logic [WIDTH-1:0] req_address,
  input  logic [WIDTH-1:0] req_write_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_read_data,
  output logic             rsp_fault,
  output logic [7:0]       fault_count
);

  localparam int ADDRESS_WIDTH = $clog2(RAM_SIZE);
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [31:0] load_value(input logic [1:0] size, input logic sx,
                                             input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
    logic [15:0] half;
    half = BIG_ENDIAN ? {b0, b1} : {b1, b0};
    case (size)
      SIZE_BYTE: load_value = sx ? {{24{b0[7]}}, b0} : {24'd0, b0};
      SIZE_HALF: load_value = sx ? {{16{half[15]}}, half} : {16'd0, half};
      SIZE_WORD: load_value = BIG_ENDIAN ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
      default:   load_value = 32'd0;
    endcase
  endfunction

  logic [7:0]               mem_q [RAM_SIZE];
  logic [READ_LATENCY-1:0]  valid_q;
  logic [READ_LATENCY-1:0]  fault_q;
  logic [WIDTH-1:0]         data_q [READ_LATENCY];
  logic [7:0]               fault_count_q;

  logic [ADDRESS_WIDTH-1:0] byte_addr_s [4];
  logic [7:0]               rd_byte_s [4];
  logic [7:0]               wr_byte_s [4];
  logic [3:0]               wr_en_s;
  logic                     stall_s;
  logic                     accept_s;
  logic                     misalign_s;
  logic                     fault_s;
  logic [WIDTH-1:0]         s0_data_d;
  logic                     unused_addr_s;

  // Address bits above the RAM size are ignored so accesses wrap.
  assign unused_addr_s = ^req_address[WIDTH-1:ADDRESS_WIDTH];

  assign stall_s  = valid_q[READ_LATENCY-1] && !rsp_ready;
  assign accept_s = req_valid && !stall_s;

  // Lane addresses wrap naturally within the truncated address width.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr_s[k] = req_address[ADDRESS_WIDTH-1:0] + ADDRESS_WIDTH'(k);
      rd_byte_s[k]   = mem_q[byte_addr_s[k]];
    end
  end

  // Fault classification: alignment, reserved size, and load/store exclusivity.
  always_comb begin
    misalign_s = 1'b0;
    case (req_size)
      SIZE_BYTE: misalign_s = 1'b0;
      SIZE_HALF: misalign_s = req_address[0];
      SIZE_WORD: misalign_s = (req_address[1:0] != 2'b00);
      default:   misalign_s = 1'b1;
    endcase
    fault_s = misalign_s || (req_load == req_store);
  end

  // Store lane steering: right-aligned data placed upward from the address in the chosen byte order.
  always_comb begin
    int nbytes;
    nbytes = 0;
    case (req_size)
      SIZE_BYTE: nbytes = 1;
      SIZE_HALF: nbytes = 2;
      SIZE_WORD: nbytes = 4;
      default:   nbytes = 0;
    endcase
    for (int k = 0; k < 4; k++) begin
      wr_en_s[k]   = 1'b0;
      wr_byte_s[k] = 8'd0;
      if (k < nbytes) begin
        wr_en_s[k]   = 1'b1;
        wr_byte_s[k] = BIG_ENDIAN ? req_write_data[8*(nbytes-1-k) +: 8] : req_write_data[8*k +: 8];
      end else begin
        wr_en_s[k]   = 1'b0;
      end
    end
  end

  // Stage-0 payload: load data only for clean loads, zero for stores and faults.
  always_comb begin
    if (req_load && !fault_s) begin
      s0_data_d = load_value(req_size, req_sign_extend, rd_byte_s[0], rd_byte_s[1],
                             rd_byte_s[2], rd_byte_s[3]);
    end else begin
      s0_data_d = 32'd0;
    end
  end

  // RAM write port; contents are never reset and a store coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (nrst && accept_s && req_store && !fault_s) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en_s[k]) mem_q[byte_addr_s[k]] <= wr_byte_s[k];
      end
    end
  end

  // Response pipeline; every stage holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid_q <= '0;
      fault_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= 32'd0;
    end else if (!stall_s) begin
      valid_q[0] <= accept_s;
      fault_q[0] <= accept_s && fault_s;
      data_q[0]  <= accept_s ? s0_data_d : 32'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        fault_q[i] <= fault_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Saturating count of consumed faulted responses.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      fault_count_q <= 8'd0;
    end else if (valid_q[READ_LATENCY-1] && rsp_ready && fault_q[READ_LATENCY-1] &&
                 (fault_count_q != 8'hFF)) begin
      fault_count_q <= fault_count_q + 8'd1;
    end
  end

  assign req_ready     = !stall_s;
  assign rsp_valid     = valid_q[READ_LATENCY-1];
  assign rsp_fault     = fault_q[READ_LATENCY-1];
  assign rsp_read_data = data_q[READ_LATENCY-1];
  assign fault_count   = fault_count_q;

endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width in bits; only 32 is supported.
REQ-002 SHALL have parameter RAM_SIZE, default 4096, byte capacity, power of two; ADDRESS_WIDTH = clog2(RAM_SIZE).
REQ-003 SHALL have parameter READ_LATENCY, default 1, range 1..4, cycles from acceptance to response.
REQ-004 SHALL have parameter BIG_ENDIAN, default 1; 1 = byte at lowest address is MSB, 0 = it is LSB.
REQ-005 SHALL have one clock; reset is synchronous and active-low: clk  in  1  rising-edge clock.
REQ-006 SHALL have port nrst  in  1  synchronous active-low reset.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-009 SHALL have port req_load  in  1  load request.
REQ-010 SHALL have port req_store  in  1  store request.
REQ-011 SHALL have port req_size  in  2  0=BYTE, 1=HALF_WORD, 2=WORD, 3=reserved.
REQ-012 SHALL have port req_sign_extend  in  1  sign-extend load result.
REQ-013 SHALL have port req_address  in  WIDTH  byte address.
REQ-014 SHALL have port req_write_data  in  WIDTH  store data, right-aligned.
REQ-015 SHALL have port rsp_valid  out  1  response present.
REQ-016 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-017 SHALL have port rsp_read_data  out  WIDTH  load result, right-aligned, 0 for stores and faults.
REQ-018 SHALL have port rsp_fault  out  1  request faulted.
REQ-019 SHALL have port fault_count  out  8  saturating count of faulted requests.

Function
REQ-020 SHALL accept a request on a rising edge where req_valid and req_ready are both high.
REQ-021 SHALL drive req_ready = !(rsp_valid && !rsp_ready); when stalled, all pipeline stages hold.
REQ-022 SHALL present each accepted request's response exactly READ_LATENCY unstalled cycles after acceptance, in order; full throughput is one request per cycle.
REQ-023 SHALL use address_trunc = req_address[ADDRESS_WIDTH-1:0] and wrap modulo RAM_SIZE.
REQ-024 SHALL fault on any of: HALF_WORD with address[0]=1, WORD with address[1:0]!=0, req_size=3, load and store both set, or neither set.
REQ-025 SHALL suppress the RAM write on a faulted store, set rsp_fault=1, and drive rsp_read_data=0.
REQ-026 SHALL write on a non-faulted store at the acceptance edge: 1, 2 or 4 bytes from the low bits of req_write_data, placed at address_trunc upward and ordered per BIG_ENDIAN.
REQ-027 SHALL sample load bytes at the acceptance edge; a load accepted the cycle after a store to the same bytes returns the new data.
REQ-028 SHALL zero-extend load data by default; with req_sign_extend set, BYTE loads replicate bit 7 and HALF_WORD loads replicate bit 15 into the upper bits; WORD loads ignore the flag.
REQ-029 SHALL return rsp_read_data=0 with rsp_fault=0 for a non-faulted store.
REQ-030 SHALL increment fault_count by 1 when a faulted response is consumed (rsp_valid && rsp_ready && rsp_fault), saturating at 255.
REQ-031 SHALL not reset RAM contents; RAM contents are undefined until written.

Reset
REQ-032 SHALL, on a clk edge with nrst=0, clear all pipeline valid bits, rsp_valid, rsp_read_data, rsp_fault and fault_count to 0.
REQ-033 SHALL not perform a store presented on the same edge as an active reset, and SHALL drop all in-flight responses.
REQ-034 SHALL hold req_ready=1 during and immediately after reset.

Verification
REQ-035 SHALL verify, with BIG_ENDIAN=1 and READ_LATENCY=1: store WORD 0x11223344 at 0x10, then load BYTE at 0x11 -> rsp_read_data=0x00000022 one cycle after acceptance; load HALF at 0x12 with sign extend -> 0x00003344.
REQ-036 SHALL verify: store BYTE 0x80 at 0x20, then load BYTE at 0x20 with sign extend -> 0xFFFFFF80; without sign extend -> 0x00000080.
REQ-037 SHALL verify: load WORD at 0x13 -> rsp_fault=1 and data 0; store HALF at 0x21 -> fault, RAM unchanged; fault_count=2 after both responses are consumed.
REQ-038 SHALL verify, with READ_LATENCY=3: issue 4 back-to-back loads, hold rsp_ready=0 for 2 cycles at the first response -> req_ready=0 while stalled, and all 4 responses arrive in order with no loss or duplication.
REQ-039 SHALL verify: assert nrst=0 with 2 loads in flight and a simultaneous store -> no responses emerge, the store's target bytes are unchanged, and fault_count=0.
REQ-040 SHALL verify: drive 300 faulting requests -> fault_count saturates at 255; address 0x1000+4 with RAM_SIZE=4096 aliases to 0x4.
